// File: rtl/psdifir_pkg.sv
// Package: psdifir_pkg
// Shared definitions for the FIR MAC sequencer: default parameter values,
// channel index constants and the sequencer state enumeration.
package psdifir_pkg;

  localparam int NTAPS_DEF     = 16384;
  localparam int ADDR_W_DEF    = 14;
  localparam int DW_DEF        = 18;
  localparam int ACC_W_DEF     = 48;
  localparam int PIPE_LAT_DEF  = 3;
  localparam int OUT_SHIFT_DEF = 17;

  // Channel index; forms the MSB of the sample RAM address.
  localparam logic CH_LEFT  = 1'b0;
  localparam logic CH_RIGHT = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    WR_L,
    WR_R,
    RUN,
    DRAIN,
    LATCH,
    DONE
  } state_t;

endpackage

// File: rtl/psdifir_mac_sequencer_if.sv
// Interface: psdifir_mac_sequencer_if
// Bus between the MAC sequencer and the shared sample RAM / coefficient ROM /
// MAC datapath.
//   smp_we     sample RAM write enable
//   smp_addr   sample RAM address {ch, ptr}
//   smp_wdata  sample RAM write data
//   coef_addr  coefficient ROM address (tap index)
//   mac_clear  zero accumulator together with the first mac_en of a channel
//   mac_en     accumulate product for the address issued this cycle
//   acc_in     accumulator value returned by the MAC
// Modports: master = sequencer side, slave = RAM/ROM/MAC side.
interface psdifir_mac_sequencer_if
  import psdifir_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DW     = DW_DEF,
  parameter int ACC_W  = ACC_W_DEF
) ();

  logic                    smp_we;
  logic [ADDR_W:0]         smp_addr;
  logic signed [DW-1:0]    smp_wdata;
  logic [ADDR_W-1:0]       coef_addr;
  logic                    mac_clear;
  logic                    mac_en;
  logic signed [ACC_W-1:0] acc_in;

  modport master (
    output smp_we, smp_addr, smp_wdata, coef_addr, mac_clear, mac_en,
    input  acc_in
  );

  modport slave (
    input  smp_we, smp_addr, smp_wdata, coef_addr, mac_clear, mac_en,
    output acc_in
  );

endinterface

// File: rtl/psdifir_round_sat.sv
// Module: psdifir_round_sat
// Combinational round-half-up and saturate from the MAC accumulator width to
// the output sample width: y = sat((acc + 2^(OUT_SHIFT-1)) >>> OUT_SHIFT).
// Ports:
//   acc  in  ACC_W  signed accumulator value
//   y    out DW     signed rounded/saturated result
module psdifir_round_sat
  import psdifir_pkg::*;
#(
  parameter int ACC_W     = ACC_W_DEF,
  parameter int DW        = DW_DEF,
  parameter int OUT_SHIFT = OUT_SHIFT_DEF
) (
  input  logic signed [ACC_W-1:0] acc,
  output logic signed [DW-1:0]    y
);

  localparam logic signed [ACC_W:0] HALF = (ACC_W+1)'(1) << (OUT_SHIFT - 1);

  logic signed [ACC_W:0]  sum;
  logic signed [ACC_W:0]  shifted;
  logic [ACC_W-DW+1:0]    top;

  always_comb begin
    // One extra bit so adding the rounding constant can never wrap.
    sum     = $signed({acc[ACC_W-1], acc}) + HALF;
    shifted = sum >>> OUT_SHIFT;
    // The result fits when every bit from the output sign bit upward agrees.
    top     = shifted[ACC_W:DW-1];
    y       = shifted[DW-1:0];
    if (!(&top || ~|top)) begin
      if (shifted[ACC_W]) y = {1'b1, {(DW-1){1'b0}}};
      else                y = {1'b0, {(DW-1){1'b1}}};
    end
  end

endmodule

// File: rtl/psdifir_mac_sequencer.sv
// Module: psdifir_mac_sequencer
// Sequences the shared FIR MAC datapath: writes each stereo sample pair into
// the circular sample RAM, runs the single MAC over the left then the right
// channel (NTAPS taps each), rounds/saturates the accumulator and pulses
// dataout_ready.
// Ports:
//   clock, reset_n          clock and synchronous active-low reset
//   datain_ready            one-cycle pulse, left_in/right_in valid
//   left_in, right_in       input samples
//   bus (master)            sample RAM / coefficient ROM / MAC bus
//   left_out, right_out     filtered outputs, held until next update
//   dataout_ready           one-cycle pulse, outputs updated
//   busy                    high whenever not IDLE
//   overrun                 sticky, input arrived while busy
// Configuration macro: PSDIFIR_SEQ_MONO_EN -- left channel only; the right
//   write and right MAC pass are skipped and right_out stays 0.
module psdifir_mac_sequencer
  import psdifir_pkg::*;
#(
  parameter int NTAPS     = NTAPS_DEF,
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int DW        = DW_DEF,
  parameter int ACC_W     = ACC_W_DEF,
  parameter int PIPE_LAT  = PIPE_LAT_DEF,
  parameter int OUT_SHIFT = OUT_SHIFT_DEF
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 datain_ready,
  input  logic signed [DW-1:0] left_in,
  input  logic signed [DW-1:0] right_in,
  psdifir_mac_sequencer_if.master bus,
  output logic signed [DW-1:0] left_out,
  output logic signed [DW-1:0] right_out,
  output logic                 dataout_ready,
  output logic                 busy,
  output logic                 overrun
);

  localparam int CNT_W = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;

  state_t               state_reg, state_next;
  logic [ADDR_W-1:0]    wptr_reg;
  logic [ADDR_W-1:0]    k_reg;
  logic                 ch_reg;
  logic [CNT_W-1:0]     drain_reg;
  logic signed [DW-1:0] left_cap_reg;
`ifndef PSDIFIR_SEQ_MONO_EN
  logic signed [DW-1:0] right_cap_reg;
`endif
  logic signed [DW-1:0] left_out_reg;
  logic signed [DW-1:0] right_out_reg;
  logic                 overrun_reg;

  logic                 last_tap;
  logic                 drain_done;
  logic signed [DW-1:0] rs_y;

  assign last_tap   = (k_reg == ADDR_W'(NTAPS - 1));
  assign drain_done = (drain_reg == CNT_W'(PIPE_LAT - 1));

  // Single rounding stage shared by both channels; LATCH steers it by ch.
  psdifir_round_sat #(
    .ACC_W     (ACC_W),
    .DW        (DW),
    .OUT_SHIFT (OUT_SHIFT)
  ) u_round_sat (
    .acc (bus.acc_in),
    .y   (rs_y)
  );

  always_comb begin
    state_next    = state_reg;
    bus.smp_we    = 1'b0;
    bus.smp_addr  = '0;
    bus.smp_wdata = '0;
    bus.coef_addr = '0;
    bus.mac_en    = 1'b0;
    bus.mac_clear = 1'b0;
    dataout_ready = 1'b0;
    busy          = (state_reg != IDLE);

    case (state_reg)
      IDLE: begin
        if (datain_ready) state_next = WR_L;
      end
      WR_L: begin
        bus.smp_we    = 1'b1;
        bus.smp_addr  = {CH_LEFT, wptr_reg};
        bus.smp_wdata = left_cap_reg;
`ifdef PSDIFIR_SEQ_MONO_EN
        state_next    = RUN;
`else
        state_next    = WR_R;
`endif
      end
      WR_R: begin
`ifndef PSDIFIR_SEQ_MONO_EN
        bus.smp_we    = 1'b1;
        bus.smp_addr  = {CH_RIGHT, wptr_reg};
        bus.smp_wdata = right_cap_reg;
`endif
        state_next    = RUN;
      end
      RUN: begin
        // Newest sample pairs with tap 0; the subtraction wraps around the
        // circular buffer by construction.
        bus.smp_addr  = {ch_reg, wptr_reg - k_reg};
        bus.coef_addr = k_reg;
        bus.mac_en    = 1'b1;
        bus.mac_clear = (k_reg == '0);
        if (last_tap) state_next = DRAIN;
      end
      DRAIN: begin
        if (drain_done) state_next = LATCH;
      end
      LATCH: begin
`ifdef PSDIFIR_SEQ_MONO_EN
        state_next = DONE;
`else
        state_next = (ch_reg == CH_LEFT) ? RUN : DONE;
`endif
      end
      DONE: begin
        dataout_ready = 1'b1;
        state_next    = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_reg     <= IDLE;
      wptr_reg      <= '0;
      k_reg         <= '0;
      ch_reg        <= CH_LEFT;
      drain_reg     <= '0;
      left_cap_reg  <= '0;
`ifndef PSDIFIR_SEQ_MONO_EN
      right_cap_reg <= '0;
`endif
      left_out_reg  <= '0;
      right_out_reg <= '0;
      overrun_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (datain_ready && (state_reg != IDLE)) overrun_reg <= 1'b1;

      case (state_reg)
        IDLE: begin
          if (datain_ready) begin
            left_cap_reg  <= left_in;
`ifndef PSDIFIR_SEQ_MONO_EN
            right_cap_reg <= right_in;
`endif
            wptr_reg      <= wptr_reg + ADDR_W'(1);
            ch_reg        <= CH_LEFT;
          end
        end
        RUN: begin
          // NTAPS is the full address range, so k returns to 0 by itself.
          k_reg     <= k_reg + ADDR_W'(1);
          drain_reg <= '0;
        end
        DRAIN: begin
          drain_reg <= drain_reg + CNT_W'(1);
        end
        LATCH: begin
          if (ch_reg == CH_LEFT) left_out_reg  <= rs_y;
          else                   right_out_reg <= rs_y;
`ifndef PSDIFIR_SEQ_MONO_EN
          ch_reg <= ~ch_reg;
`endif
        end
        default: ;
      endcase
    end
  end

  assign left_out  = left_out_reg;
  assign right_out = right_out_reg;
  assign overrun   = overrun_reg;

endmodule

// File: tb/tb_psdifir_mac_sequencer.sv
// Testbench for psdifir_mac_sequencer with a small behavioural RAM/ROM/MAC
// model and a golden FIR reference. Honours PSDIFIR_SEQ_MONO_EN.
module tb_psdifir_mac_sequencer;

  localparam int NTAPS     = 16;
  localparam int ADDR_W    = 4;
  localparam int DW        = 18;
  localparam int ACC_W     = 48;
  localparam int PIPE_LAT  = 3;
  localparam int OUT_SHIFT = 17;
`ifdef PSDIFIR_SEQ_MONO_EN
  localparam bit MONO = 1'b1;
  localparam int LAT  = 2 + (NTAPS + PIPE_LAT + 1);
`else
  localparam bit MONO = 1'b0;
  localparam int LAT  = 3 + 2 * (NTAPS + PIPE_LAT + 1);
`endif

  logic                 clock = 1'b0;
  logic                 reset_n;
  logic                 datain_ready;
  logic signed [DW-1:0] left_in, right_in;
  logic signed [DW-1:0] left_out, right_out;
  logic                 dataout_ready, busy, overrun;

  psdifir_mac_sequencer_if #(.ADDR_W(ADDR_W), .DW(DW), .ACC_W(ACC_W)) bus_if ();

  psdifir_mac_sequencer #(
    .NTAPS(NTAPS), .ADDR_W(ADDR_W), .DW(DW), .ACC_W(ACC_W),
    .PIPE_LAT(PIPE_LAT), .OUT_SHIFT(OUT_SHIFT)
  ) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .datain_ready  (datain_ready),
    .left_in       (left_in),
    .right_in      (right_in),
    .bus           (bus_if),
    .left_out      (left_out),
    .right_out     (right_out),
    .dataout_ready (dataout_ready),
    .busy          (busy),
    .overrun       (overrun)
  );

  always #5 clock = ~clock;

  // ---------------- RAM / ROM / MAC environment model ----------------
  logic signed [DW-1:0] ram [0:2*NTAPS-1];
  longint               coef [0:NTAPS-1];
  longint               acc;
  bit                   pv [0:1];
  bit                   pc [0:1];
  longint               pp [0:1];

  // Registered RAM read + product, then one more stage, then accumulate:
  // the accumulator reflects an issue three edges after it was presented.
  always @(posedge clock) begin
    if (bus_if.smp_we) ram[bus_if.smp_addr] <= bus_if.smp_wdata;
    if (pv[1]) acc <= (pc[1] ? 64'sd0 : acc) + pp[1];
    pv[1] <= pv[0];
    pc[1] <= pc[0];
    pp[1] <= pp[0];
    pv[0] <= bus_if.mac_en;
    pc[0] <= bus_if.mac_clear;
    pp[0] <= longint'(ram[bus_if.smp_addr]) * coef[bus_if.coef_addr];
  end

  assign bus_if.acc_in = acc[ACC_W-1:0];

  // ---------------- golden reference ----------------
  longint gl [0:NTAPS-1];
  longint gr [0:NTAPS-1];
  int     gptr;
  int     n_checks = 0;
  int     n_errors = 0;
  int     n_samples = 0;
  int     wraps_seen = 0;
  int     last_wr_addr = -1;

  function automatic longint rnd_sat(input longint a);
    longint y;
    y = (a + (longint'(1) << (OUT_SHIFT - 1))) >>> OUT_SHIFT;
    if (y > 131071)  y = 131071;
    if (y < -131072) y = -131072;
    return y;
  endfunction

  function automatic longint fir_out(input bit ch);
    longint s = 0;
    for (int k = 0; k < NTAPS; k++) begin
      int idx = (gptr - k + NTAPS) % NTAPS;
      s += coef[k] * (ch ? gr[idx] : gl[idx]);
    end
    return rnd_sat(s);
  endfunction

  task automatic check_val(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Issue one sample pair and follow it to dataout_ready. inject_at > 0 pulses
  // a second datain_ready at that cycle (must be ignored).
  task automatic send_sample(input logic signed [DW-1:0] l, input logic signed [DW-1:0] r,
                             input int inject_at);
    int cyc;
    bit got_rdy;
    bit stray_we;
    @(posedge clock); #1;
    datain_ready = 1'b1;
    left_in      = l;
    right_in     = r;
    @(posedge clock); #1;
    datain_ready = 1'b0;
    left_in      = DW'($urandom);
    right_in     = DW'($urandom);
    gptr = (gptr + 1) % NTAPS;
    gl[gptr] = longint'(l);
    gr[gptr] = longint'(r);
    n_samples++;
    cyc = 0; got_rdy = 1'b0; stray_we = 1'b0;
    while (cyc < LAT + 20 && !got_rdy) begin
      @(negedge clock);
      cyc++;
      if (cyc == 1) begin
        check_val("wr_l_we", longint'(bus_if.smp_we), 1);
        check_val("wr_l_addr", longint'(bus_if.smp_addr), longint'(gptr));
        check_val("wr_l_data", longint'(bus_if.smp_wdata), longint'(l));
        if (last_wr_addr == NTAPS - 1 && int'(bus_if.smp_addr) == 0) wraps_seen++;
        last_wr_addr = int'(bus_if.smp_addr);
      end else if (cyc == 2) begin
        check_val("wr_r_we", longint'(bus_if.smp_we), MONO ? 0 : 1);
        if (!MONO) begin
          check_val("wr_r_addr", longint'(bus_if.smp_addr), longint'(NTAPS + gptr));
          check_val("wr_r_data", longint'(bus_if.smp_wdata), longint'(r));
        end
      end else if (bus_if.smp_we) begin
        stray_we = 1'b1;
      end
      if (inject_at > 0 && cyc == inject_at) begin
        datain_ready = 1'b1;
        left_in      = DW'($urandom);
      end else if (inject_at > 0 && cyc == inject_at + 1) begin
        datain_ready = 1'b0;
      end
      if (dataout_ready) got_rdy = 1'b1;
    end
    check_val("rdy_seen", longint'(got_rdy), 1);
    check_val("stray_we", longint'(stray_we), 0);
    if (got_rdy) begin
      check_val("latency", longint'(cyc), longint'(LAT));
      check_val("left_out", longint'(left_out), fir_out(1'b0));
      check_val("right_out", longint'(right_out), MONO ? 0 : fir_out(1'b1));
      $display("sample %0d: in L=%0d R=%0d out L=%0d R=%0d latency=%0d",
               n_samples, l, r, left_out, right_out, cyc);
      @(negedge clock);
      check_val("rdy_width", longint'(dataout_ready), 0);
      check_val("busy_after", longint'(busy), 0);
    end
  endtask

  // Issue a sample, then pull reset while the first pass is draining.
  task automatic reset_in_drain(input logic signed [DW-1:0] l, input logic signed [DW-1:0] r);
    bit seen;
    @(posedge clock); #1;
    datain_ready = 1'b1;
    left_in      = l;
    right_in     = r;
    @(posedge clock); #1;
    datain_ready = 1'b0;
    gptr = (gptr + 1) % NTAPS;
    gl[gptr] = longint'(l);
    gr[gptr] = longint'(r);
    // Cycles 3..18 are the first RUN pass (2 in mono); 20 lands in DRAIN.
    repeat (MONO ? 19 : 20) @(negedge clock);
    reset_n = 1'b0;
    @(negedge clock);
    check_val("abort_left", longint'(left_out), 0);
    check_val("abort_right", longint'(right_out), 0);
    check_val("abort_overrun", longint'(overrun), 0);
    check_val("abort_busy", longint'(busy), 0);
    check_val("abort_mac_en", longint'(bus_if.mac_en), 0);
    reset_n = 1'b1;
    gptr = 0;
    seen = 1'b0;
    repeat (LAT + 20) begin
      @(negedge clock);
      if (dataout_ready) seen = 1'b1;
    end
    check_val("abort_no_rdy", longint'(seen), 0);
    $display("sample aborted by reset: in L=%0d R=%0d", l, r);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic signed [DW-1:0] rl, rr;
    longint rnd_in  [0:3];
    longint rnd_exp [0:3];

    for (int i = 0; i < 2 * NTAPS; i++) ram[i] = '0;
    for (int i = 0; i < NTAPS; i++) begin
      coef[i] = 0; gl[i] = 0; gr[i] = 0;
    end
    acc = 0;
    for (int i = 0; i < 2; i++) begin pv[i] = 0; pc[i] = 0; pp[i] = 0; end
    gptr = 0;
    reset_n = 1'b0; datain_ready = 1'b0; left_in = '0; right_in = '0;

    repeat (3) @(posedge clock);
    @(negedge clock);
    check_val("rst_left", longint'(left_out), 0);
    check_val("rst_right", longint'(right_out), 0);
    check_val("rst_rdy", longint'(dataout_ready), 0);
    check_val("rst_busy", longint'(busy), 0);
    check_val("rst_overrun", longint'(overrun), 0);
    check_val("rst_we", longint'(bus_if.smp_we), 0);
    check_val("rst_mac_en", longint'(bus_if.mac_en), 0);
    reset_n = 1'b1;
    @(negedge clock);
    check_val("idle_busy", longint'(busy), 0);

    // Impulse response through coef[k] = k<<17.
    for (int k = 0; k < NTAPS; k++) coef[k] = longint'(k) << 17;
    send_sample(18'sd65536, 18'sd0, 0);
    for (int n = 1; n < 20; n++) send_sample(18'sd0, 18'sd0, 0);

    // Rounding: single unity tap makes acc equal to the input.
    for (int k = 0; k < NTAPS; k++) coef[k] = 0;
    coef[0] = 1;
    rnd_in[0] = 65536;  rnd_exp[0] = 1;
    rnd_in[1] = 65535;  rnd_exp[1] = 0;
    rnd_in[2] = -65536; rnd_exp[2] = 0;
    rnd_in[3] = -65537; rnd_exp[3] = -1;
    for (int i = 0; i < 4; i++) begin
      rl = DW'(rnd_in[i]);
      send_sample(rl, DW'($urandom), 0);
      check_val("round", longint'(left_out), rnd_exp[i]);
    end

    // Saturation, both rails.
    for (int k = 0; k < NTAPS; k++) coef[k] = 131071;
    for (int n = 0; n < NTAPS; n++) send_sample(18'sd131071, 18'sd131071, 0);
    check_val("sat_pos", longint'(left_out), 131071);
    for (int n = 0; n < NTAPS; n++) send_sample(-18'sd131072, -18'sd131072, 0);
    check_val("sat_neg", longint'(left_out), -131072);

    // Random coefficients and 40 random samples across pointer wrap.
    for (int k = 0; k < NTAPS; k++) coef[k] = longint'($urandom_range(0, 8191)) - 4096;
    wraps_seen = 0;
    for (int n = 0; n < 40; n++) begin
      rl = DW'($urandom);
      rr = DW'($urandom);
      send_sample(rl, rr, 0);
    end
    check_val("wrap_seen", longint'(wraps_seen >= 2), 1);

    // Overrun: a second pulse mid-RUN is dropped and sets the sticky flag.
    check_val("overrun_pre", longint'(overrun), 0);
    rl = DW'($urandom); rr = DW'($urandom);
    send_sample(rl, rr, 10);
    check_val("overrun_set", longint'(overrun), 1);
    rl = DW'($urandom); rr = DW'($urandom);
    send_sample(rl, rr, 0);
    check_val("overrun_sticky", longint'(overrun), 1);

    // Reset while draining, then a normal sample.
    rl = DW'($urandom); rr = DW'($urandom);
    reset_in_drain(rl, rr);
    rl = DW'($urandom); rr = DW'($urandom);
    send_sample(rl, rr, 0);
    check_val("overrun_cleared", longint'(overrun), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
